// File: rtl/csr_result_streamer.sv
// csr_result_streamer: snapshots a CSR matrix (NVC/CIC/RPC) on core completion
// and streams one (row, col, value) beat per stored non-zero over valid/ready.
module csr_result_streamer #(
  parameter int NNZ_MAX = 16,
  parameter int DW      = 32,
  parameter int IW      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  op_complete_i,
  input  logic [IW-1:0]         rows_i,
  input  logic [NNZ_MAX*DW-1:0] NVC_i,
  input  logic [NNZ_MAX*DW-1:0] CIC_i,
  input  logic [NNZ_MAX*DW-1:0] RPC_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [IW-1:0]         m_row_o,
  output logic [IW-1:0]         m_col_o,
  output logic [DW-1:0]         m_val_o,
  output logic                  m_last_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int PW = IW + 1;
  localparam int BW = NNZ_MAX * DW;
  localparam logic [PW-1:0] NNZ = PW'(NNZ_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROW,
    S_EMIT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_nv [NNZ_MAX];
  logic [IW-1:0] r_ci [NNZ_MAX];
  logic [PW-1:0] r_rp [NNZ_MAX];
  logic [IW-1:0] r_rows;
  logic [IW-1:0] r_row;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_end;
  logic          r_opc_q;

  logic [IW-1:0] w_row_nx;
  logic [PW-1:0] w_s;
  logic [PW-1:0] w_e;
  logic [PW-1:0] w_s1;
  logic [PW-1:0] w_ptr1;
  logic [PW-1:0] w_ptr2;
  logic [PW-1:0] w_tot;
  logic [NNZ_MAX-1:0] w_unused_bits;

  assign w_row_nx = r_row + 1'b1;
  assign w_s      = r_rp[r_row];
  assign w_e      = r_rp[w_row_nx];
  assign w_s1     = w_s + 1'b1;
  assign w_ptr1   = r_ptr + 1'b1;
  assign w_ptr2   = r_ptr + 2'd2;
  assign w_tot    = r_rp[r_rows];

  always_comb begin
    w_unused_bits = '0;
    for (int k = 0; k < NNZ_MAX; k++) begin
      w_unused_bits[k] = ^{CIC_i[BW-1-DW*k -: DW-IW],
                           RPC_i[BW-1-DW*k -: DW-PW]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_row     <= '0;
      r_ptr     <= '0;
      r_end     <= '0;
      r_opc_q   <= 1'b0;
      m_valid_o <= 1'b0;
      m_row_o   <= '0;
      m_col_o   <= '0;
      m_val_o   <= '0;
      m_last_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      for (int k = 0; k < NNZ_MAX; k++) begin
        r_nv[k] <= '0;
        r_ci[k] <= '0;
        r_rp[k] <= '0;
      end
    end else begin
      r_opc_q <= op_complete_i;
      unique case (r_state)
        S_IDLE: begin
          if (op_complete_i && !r_opc_q) begin
            for (int k = 0; k < NNZ_MAX; k++) begin
              r_nv[k] <= NVC_i[BW-1-DW*k -: DW];
              r_ci[k] <= CIC_i[BW-DW*(k+1) +: IW];
              r_rp[k] <= RPC_i[BW-DW*(k+1) +: PW];
            end
            r_rows  <= rows_i;
            r_row   <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b1;
            r_state <= S_ROW;
          end
        end
        S_ROW: begin
          if (r_row == r_rows) begin
            done_o  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_e < w_s || w_e > NNZ) begin
            err_o <= 1'b1;
            r_row <= w_row_nx;
          end else if (w_s == w_e) begin
            r_row <= w_row_nx;
          end else begin
            r_ptr     <= w_s;
            r_end     <= w_e;
            m_valid_o <= 1'b1;
            m_row_o   <= r_row;
            m_col_o   <= r_ci[w_s[IW-1:0]];
            m_val_o   <= r_nv[w_s[IW-1:0]];
            // last only at a row end, so a non-monotonic RP cannot cut a row short
            m_last_o  <= (w_s1 == w_tot) && (w_s1 == w_e);
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (m_ready_i) begin
            if (m_last_o) begin
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              done_o    <= 1'b1;
              r_state   <= S_DONE;
            end else if (w_ptr1 == r_end) begin
              m_valid_o <= 1'b0;
              r_row     <= w_row_nx;
              r_state   <= S_ROW;
            end else begin
              r_ptr    <= w_ptr1;
              m_col_o  <= r_ci[w_ptr1[IW-1:0]];
              m_val_o  <= r_nv[w_ptr1[IW-1:0]];
              m_last_o <= (w_ptr2 == w_tot) && (w_ptr2 == r_end);
            end
          end
        end
        S_DONE: begin
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_result_streamer.sv
// tb_csr_result_streamer: randomized + directed scoreboard bench for the
// CSR result streamer, checked against a row-by-row reference model.
module tb_csr_result_streamer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         opc = 1'b0;
  logic [3:0]   rows = '0;
  logic [511:0] nvc = '0;
  logic [511:0] cic = '0;
  logic [511:0] rpc = '0;
  logic         ready = 1'b0;
  logic         m_valid;
  logic [3:0]   m_row;
  logic [3:0]   m_col;
  logic [31:0]  m_val;
  logic         m_last;
  logic         busy;
  logic         done;
  logic         err;

  csr_result_streamer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .op_complete_i(opc),
    .rows_i       (rows),
    .NVC_i        (nvc),
    .CIC_i        (cic),
    .RPC_i        (rpc),
    .m_valid_o    (m_valid),
    .m_ready_i    (ready),
    .m_row_o      (m_row),
    .m_col_o      (m_col),
    .m_val_o      (m_val),
    .m_last_o     (m_last),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    int          col;
    logic [31:0] val;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    done_cnt = 0;
  int    hs_cnt = 0;
  int    rdy_mode = 0;
  bit    mon_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: ready = 1'b1;
      1: ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  // monitor: pops the scoreboard on each handshake, checks stalls hold
  initial begin
    bit    stall;
    beat_t pb;
    beat_t e;
    stall = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en) begin
        if (done) done_cnt++;
        if (stall) begin
          chk("stall_hold", {m_valid, m_row, m_col, m_val, m_last},
              {1'b1, 4'(pb.row), 4'(pb.col), pb.val, pb.last});
        end
        if (m_valid && ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", {m_row, m_col, m_val}, 0);
          end else begin
            e = exp_q.pop_front();
            chk("beat_row", m_row, e.row);
            chk("beat_col", m_col, e.col);
            chk("beat_val", m_val, e.val);
            chk("beat_last", m_last, e.last);
          end
        end
        stall = m_valid && !ready;
        pb.row = m_row;
        pb.col = m_col;
        pb.val = m_val;
        pb.last = m_last;
      end else begin
        stall = 0;
      end
    end
  end

  // reference: walk rows in order, applying the row-pointer rules directly
  task automatic model(input int nr, input int rp[16], input int ci[16],
                       input int nv[16], output bit e_err);
    beat_t b;
    bit stop;
    e_err = 0;
    stop = 0;
    for (int r = 0; r < nr && !stop; r++) begin
      int s = rp[r] & 31;
      int e = rp[r+1] & 31;
      int tot = rp[nr] & 31;
      if (e < s || e > 16) begin
        e_err = 1;
        continue;
      end
      for (int p = s; p < e && !stop; p++) begin
        b.row = r;
        b.col = ci[p] & 15;
        b.val = nv[p];
        b.last = (p + 1 == tot) && (p + 1 == e);
        exp_q.push_back(b);
        if (b.last) stop = 1;
      end
    end
  endtask

  function automatic logic [511:0] pack(input int a[16]);
    logic [511:0] p;
    for (int k = 0; k < 16; k++) p[511-32*k -: 32] = a[k];
    return p;
  endfunction

  task automatic run(string nm, input int nr, input int rp[16],
                     input int ci[16], input int nv[16], input int mode);
    bit e_err;
    int d0;
    int t;
    model(nr, rp, ci, nv, e_err);
    rows = 4'(nr);
    rpc = pack(rp);
    cic = pack(ci);
    nvc = pack(nv);
    rdy_mode = mode;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    opc = 1'b1;
    t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_timeout"}, t < 400, 1);
    // op_complete held high: no second drain may start
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_cnt"}, done_cnt - d0, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_valid"}, m_valid, 0);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_left"}, exp_q.size(), 0);
    exp_q.delete();
    opc = 1'b0;
    @(posedge clk);
  endtask

  int rp1[16] = '{0, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ci1[16] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int nv1[16] = '{5, 7, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int rp3[16] = '{0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int ci3[16] = '{2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int nv3[16] = '{11, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int rp5[16] = '{0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int nv5[16] = '{21, 0, 23, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    int rp[16];
    int ci[16];
    int nv[16];
    int nr;
    int t;
    int d0;
    int h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_outs", {m_row, m_col, m_val, m_last}, 0);
    chk("rst_flags", {busy, done, err}, 0);
    rst_n = 1'b1;
    mon_en = 1;
    repeat (2) @(posedge clk);

    run("t1_basic", 2, rp1, ci1, nv1, 0);
    run("t2_bp", 2, rp1, ci1, nv1, 1);
    run("t3_empty", 3, rp3, ci3, nv3, 0);
    run("t4_zero", 0, rp1, ci1, nv1, 0);
    run("t5_bad", 2, rp5, ci1, nv5, 2);
    run("t5_clear", 2, rp1, ci1, nv1, 0);

    // reset during the second beat
    begin
      bit e_err;
      model(2, rp1, ci1, nv1, e_err);
      rows = 4'd2;
      rpc = pack(rp1);
      cic = pack(ci1);
      nvc = pack(nv1);
      rdy_mode = 0;
      h0 = hs_cnt;
      d0 = done_cnt;
      @(posedge clk);
      #2;
      opc = 1'b1;
      t = 0;
      while (hs_cnt == h0 && t < 50) begin
        @(posedge clk);
        t++;
      end
      chk("t6_first_beat", t < 50, 1);
      #2;
      chk("t6_beat2_valid", m_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_drop", m_valid, 0);
      chk("t6_rst_busy", busy, 0);
      exp_q.delete();
      opc = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t6_no_done", done_cnt - d0, 0);
    end
    run("t6_rerun", 2, rp1, ci1, nv1, 0);

    for (int n = 0; n < 40; n++) begin
      nr = $urandom_range(0, 15);
      rp[0] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0;
      for (int i = 1; i < 16; i++) begin
        if ($urandom_range(0, 9) == 0) rp[i] = $urandom_range(0, 20);
        else rp[i] = rp[i-1] + $urandom_range(0, 2);
        if (rp[i] > 16) rp[i] = ($urandom_range(0, 3) == 0) ? rp[i] : 16;
      end
      for (int i = 0; i < 16; i++) begin
        ci[i] = $urandom_range(0, 15);
        nv[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom);
      end
      run("rand", nr, rp, ci, nv, n % 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
